// File: rtl/mem_if_pkg.sv
// Shared encodings for the data-side memory responder: write-size codes,
// cache-block geometry and the block-transfer FSM states.
package mem_if_pkg;

   localparam logic [1:0] SZ_1 = 2'd1;
   localparam logic [1:0] SZ_2 = 2'd2;
   localparam logic [1:0] SZ_3 = 2'd3;
   localparam logic [1:0] SZ_4 = 2'd0;

   localparam int BLK_WORDS = 8;
   localparam int BLK_BITS  = 256;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RESP    = 2'd2,
      RELEASE = 2'd3
   } blk_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-memory data-side bus: word port plus 256-bit cache-block port.
// The master modport is the core/cache side, the slave modport is the memory.
interface data_mem_responder_if;
   import mem_if_pkg::*;

   logic [31:0]         data_address_2DM;
   logic                MemRead_2DM;
   logic                MemWrite_2DM;
   logic [31:0]         data_write_2DM;
   logic [1:0]          data_write_size_2DM;
   logic [31:0]         data_read_fDM;
   logic [BLK_BITS-1:0] block_write_2DM;
   logic [BLK_BITS-1:0] block_read_fDM;
   logic                dBlkRead;
   logic                dBlkWrite;
   logic                block_read_fDM_valid;
   logic                block_write_fDM_valid;

   modport master (
      output data_address_2DM, MemRead_2DM, MemWrite_2DM, data_write_2DM,
             data_write_size_2DM, block_write_2DM, dBlkRead, dBlkWrite,
      input  data_read_fDM, block_read_fDM, block_read_fDM_valid, block_write_fDM_valid
   );

   modport slave (
      input  data_address_2DM, MemRead_2DM, MemWrite_2DM, data_write_2DM,
             data_write_size_2DM, block_write_2DM, dBlkRead, dBlkWrite,
      output data_read_fDM, block_read_fDM, block_read_fDM_valid, block_write_fDM_valid
   );

endinterface

// File: rtl/mem_byte_lane.sv
// Maps a (byte offset, size, data) word write onto big-endian byte lanes:
// lane 0 is bits [31:24]; the low n data bytes land MSB-first from the offset.
module mem_byte_lane
   import mem_if_pkg::*;
(
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_data,
   output logic [3:0]  o_lane_en,
   output logic [31:0] o_lane_data
);

   logic [2:0] w_n;

   always_comb begin
      case (i_size)
         SZ_1:    w_n = 3'd1;
         SZ_2:    w_n = 3'd2;
         SZ_3:    w_n = 3'd3;
         SZ_4:    w_n = 3'd4;
         default: w_n = 3'd4;
      endcase
   end

   // Lanes past offset+n (or past lane 3) stay disabled, so writes never cross a word.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [2:0] w_k;
      logic [1:0] w_sel;

      assign w_k            = 3'(gi) - {1'b0, i_offset};
      assign o_lane_en[gi]  = (3'(gi) >= {1'b0, i_offset}) && (w_k < w_n);
      assign w_sel          = 2'(w_n - 3'd1 - w_k);
      assign o_lane_data[31-8*gi -: 8] = o_lane_en[gi] ? i_data[{w_sel, 3'b000} +: 8] : 8'h00;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: combinational word reads, byte-lane word writes and
// latched block reads/writes with a fixed latency and one-cycle valid pulses.
module data_mem_responder
   import mem_if_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int BLK_LATENCY = 4
) (
   input  logic                 CLK,
   input  logic                 RESET,
   data_mem_responder_if.slave  bus
);

   localparam int BASE_W = ADDR_W - 3;

   logic [31:0]         r_mem [2**ADDR_W];
   blk_state_e          r_state;
   logic [3:0]          r_cnt;
   logic                r_op_wr;
   logic [BASE_W-1:0]   r_base;
   logic [BLK_BITS-1:0] r_blk_wdata;
   logic [BLK_BITS-1:0] r_blk_rdata;
   logic                r_rd_valid;
   logic                r_wr_valid;

   logic [ADDR_W-1:0]   w_idx;
   logic [3:0]          w_lane_en;
   logic [31:0]         w_lane_data;
   logic                w_done;
   logic                w_commit;
   logic                w_snap;
   logic                w_unused;

   assign w_idx    = bus.data_address_2DM[ADDR_W+1:2];
   assign w_unused = ^bus.data_address_2DM[31:ADDR_W+2];
   assign w_done   = (r_state == BUSY) && (r_cnt == 4'd0);
   assign w_commit = w_done && r_op_wr;
   assign w_snap   = w_done && !r_op_wr;

   mem_byte_lane u_lane (
      .i_offset    (bus.data_address_2DM[1:0]),
      .i_size      (bus.data_write_size_2DM),
      .i_data      (bus.data_write_2DM),
      .o_lane_en   (w_lane_en),
      .o_lane_data (w_lane_data)
   );

   assign bus.data_read_fDM         = bus.MemRead_2DM ? r_mem[w_idx] : 32'h0;
   assign bus.block_read_fDM        = r_blk_rdata;
   assign bus.block_read_fDM_valid  = r_rd_valid;
   assign bus.block_write_fDM_valid = r_wr_valid;

   // Block FSM; RELEASE waits for both requests to drop so a held level is served once.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_op_wr     <= 1'b0;
         r_base      <= '0;
         r_blk_wdata <= '0;
         r_blk_rdata <= '0;
         r_rd_valid  <= 1'b0;
         r_wr_valid  <= 1'b0;
      end else begin
         r_rd_valid <= w_snap;
         r_wr_valid <= w_commit;
         case (r_state)
            IDLE: begin
               if (bus.dBlkWrite || bus.dBlkRead) begin
                  r_op_wr <= bus.dBlkWrite;
                  r_base  <= w_idx[ADDR_W-1:3];
                  if (bus.dBlkWrite)
                     r_blk_wdata <= bus.block_write_2DM;
                  r_cnt   <= 4'(BLK_LATENCY - 1);
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (r_cnt == 4'd0)
                  r_state <= RESP;
               else
                  r_cnt <= r_cnt - 4'd1;
            end
            RESP:    r_state <= RELEASE;
            RELEASE: begin
               if (!bus.dBlkRead && !bus.dBlkWrite)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
         if (w_snap) begin
            for (int i = 0; i < BLK_WORDS; i++)
               r_blk_rdata[BLK_BITS-1-32*i -: 32] <= r_mem[{r_base, 3'(i)}];
         end
      end
   end

   // Word write is issued after the block commit so it wins on its enabled lanes.
   always_ff @(posedge CLK) begin
      if (w_commit) begin
         for (int i = 0; i < BLK_WORDS; i++)
            r_mem[{r_base, 3'(i)}] <= r_blk_wdata[BLK_BITS-1-32*i -: 32];
      end
      if (bus.MemWrite_2DM) begin
         for (int l = 0; l < 4; l++)
            if (w_lane_en[l])
               r_mem[w_idx][31-8*l -: 8] <= w_lane_data[31-8*l -: 8];
      end
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Behavioural-synthesizable data-memory responder: the memory end of the core's data-side interface (word port plus 256-bit cache-block port).
- Serves single-cycle word reads and writes.
- Serves block reads and writes with a programmable latency and a valid handshake.
- Lets the pipeline, and later the data cache, be exercised against a cycle-accurate memory model inside RTL simulation.

Parameters:
- ADDR_W, 10, word-index width; array holds 2^ADDR_W 32-bit words.
- BLK_LATENCY, 4, cycles from block-request accept to valid pulse; legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- data_address_2DM  in  32  byte address for word and block accesses.
- MemRead_2DM  in  1  word read request.
- MemWrite_2DM  in  1  word write request.
- data_write_2DM  in  32  word write data.
- data_write_size_2DM  in  2  bytes to write: 1, 2, 3; 0 means 4.
- data_read_fDM  out  32  word read data.
- block_write_2DM  in  256  block write data.
- block_read_fDM  out  256  block read data.
- dBlkRead  in  1  block read request, level.
- dBlkWrite  in  1  block write request, level.
- block_read_fDM_valid  out  1  block read complete, 1-cycle pulse.
- block_write_fDM_valid  out  1  block write complete, 1-cycle pulse.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, counter=0, both valid outputs=0, block_read_fDM=0, latched request cleared.
  - Array contents are NOT reset.
  - Reset mid-operation aborts the access; a pending block write is discarded, with no partial commit.
- Addressing:
  - Word index = data_address_2DM[ADDR_W+1:2]; higher bits ignored, so addresses alias/wrap.
  - Byte offset = [1:0].
  - Block base = word index with low 3 bits forced to 0.
- Word read:
  - Combinational: data_read_fDM = mem[index] while MemRead_2DM=1, else 0.
  - Offset is ignored; the core extracts bytes.
- Word write:
  - Committed at the rising edge while MemWrite_2DM=1.
  - n = size (0 means 4).
  - Write byte k (k=0..n-1) goes to offset+k, big-endian lanes (offset 0 = bits[31:24]).
  - Its value is data_write_2DM[8*(n-1-k)+7 -: 8], i.e. the low n bytes, MSB first.
  - Lanes past offset 3 are dropped; no word crossing.
- Block layout: word i of the block (i=0..7) occupies bits [255-32i -: 32].
- Block FSM, states IDLE, BUSY, RESP, RELEASE:
  - IDLE: if dBlkWrite, latch the base and block_write_2DM, op=WR. Else if dBlkRead, latch the base, op=RD. Then counter=BLK_LATENCY-1 and go to BUSY. Write has priority when both requests are high.
  - BUSY: counter decrements each edge. The edge with counter==0 moves to RESP.
    - RD: snapshots 8 words into block_read_fDM.
    - WR: commits 8 words to the array.
  - RESP: the matching valid output is 1 for this one cycle only. Next state RELEASE.
  - RELEASE: stay until dBlkRead=0 and dBlkWrite=0, then IDLE. This prevents double service of a held request.
- Latency: valid is high exactly BLK_LATENCY cycles after the accepting edge.
- block_read_fDM holds its value until the next block read completes.
- Word accesses remain legal in every FSM state.
- A block read snapshot includes word writes committed before the snapshot edge.
- On the same edge, if a word write and a block-write commit hit the same word, the word write wins on its enabled lanes.
- Block data, address and request lines may change after accept without effect; they are latched.

Decomposition:
- Package mem_if_pkg:
  - size encodings SZ_1/SZ_2/SZ_3/SZ_4 = 1/2/3/0;
  - BLK_WORDS=8, BLK_BITS=256;
  - state enum {IDLE, BUSY, RESP, RELEASE}.
- One sub-module, mem_byte_lane: combinational; (offset, size, data) -> 4-bit lane enable plus lane-aligned 32-bit data.
- FSM, counter and array live in the top.

Test Plan:
- Word write, addr 0x100, size 0, data 0xDEADBEEF; then read addr 0x100 -> data_read_fDM=0xDEADBEEF. MemRead low -> 0.
- Over 0x11223344 at 0x200: size 1, addr 0x201, data 0xAA -> 0x11AA3344. Size 2, addr 0x202, data 0xBBCC -> 0x11AABBCC. Size 3 at offset 2 -> only 2 lanes written.
- Block write, base 0x400, words 0..7 = 0x0..0x7, BLK_LATENCY=4, request held:
  - block_write_fDM_valid pulses exactly 4 cycles after accept, for 1 cycle;
  - no second pulse while the request stays high;
  - word read 0x41C -> 0x7.
- Block read of 0x400 -> valid after 4 cycles; block_read_fDM[255:224]=0x0, [31:0]=0x7. A word write to 0x404=0x55 during BUSY appears in the snapshot.
- dBlkRead and dBlkWrite asserted together -> write serviced first. After both drop and dBlkRead reasserts, the read returns the newly written block.
- RESET asserted mid-BUSY of a block write -> valid stays 0, array unchanged (prior word reads match), state IDLE immediately; a new request after reset completes normally.
